debounce_scanner: RTL

Time-multiplexed debouncer for the encoder front end. It shares one debounce datapath (compare, counter increment, saturate) across `N_CH` noisy inputs such as encoder A/B and push-buttons. A round-robin scheduler gives each channel one service slot per `N_CH` clocks. Per-channel state lives in register arrays, and the block emits clean levels plus one-cycle rise/fall strobes to the decoder logic.

---
 rtl/debounce_pkg.sv | 20 ++
 rtl/sync2.sv | 23 ++
 rtl/debounce_scanner.sv | 101 ++++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types and elaboration-time helpers for debounce_scanner.
package debounce_pkg;

  typedef enum logic [1:0] {
    SVC_LOAD,
    SVC_COUNT,
    SVC_COMMIT,
    SVC_IDLE
  } svc_e;

  function automatic int ptr_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit cfg_ok(input int n_ch, input longint delay, input int cnt_w);
    return n_ch >= 2 && delay >= 0 && cnt_w >= 1 && cnt_w < 63 &&
           delay < (longint'(1) << cnt_w);
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for one asynchronous input bit.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/debounce_scanner.sv
// debounce_scanner: round-robin debouncer sharing one compare/count datapath
// across N_CH channels; emits clean levels plus one-cycle rise/fall strobes.
module debounce_scanner
  import debounce_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int DELAY = 20_000,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N_CH-1:0] noisy,
  output logic [N_CH-1:0] clean,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
);

  localparam int PW = ptr_w(N_CH);
  localparam logic [CNT_W-1:0] DLY = CNT_W'(DELAY);

  if (!cfg_ok(N_CH, longint'(DELAY), CNT_W)) begin : g_bad_cfg
    $error("debounce_scanner: need N_CH >= 2 and 0 <= DELAY < 2**CNT_W");
  end

  logic [N_CH-1:0]  s;
  logic [N_CH-1:0]  prev_q, prev_d;
  logic [N_CH-1:0]  clean_q, clean_d;
  logic [N_CH-1:0]  rise_q, rise_d;
  logic [N_CH-1:0]  fall_q, fall_d;
  logic [CNT_W-1:0] count_q [N_CH];
  logic [CNT_W-1:0] count_d [N_CH];
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             s_sel, prev_sel, clean_sel;
  logic [CNT_W-1:0] cnt_sel;
  svc_e             svc;

  for (genvar g = 0; g < N_CH; g++) begin : g_sync
    sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (noisy[g]),
      .q_o (s[g])
    );
  end

  // Shared datapath: select the serviced channel, then decide its action.
  always_comb begin
    s_sel     = s[ptr_q];
    prev_sel  = prev_q[ptr_q];
    clean_sel = clean_q[ptr_q];
    cnt_sel   = count_q[ptr_q];
    svc       = (s_sel != prev_sel)     ? SVC_LOAD   :
                (cnt_sel < DLY)         ? SVC_COUNT  :
                (clean_sel != prev_sel) ? SVC_COMMIT : SVC_IDLE;
    ptr_d     = !en ? ptr_q : (ptr_q == PW'(N_CH - 1)) ? '0 : ptr_q + 1'b1;
  end

  always_comb begin
    prev_d  = prev_q;
    clean_d = clean_q;
    count_d = count_q;
    rise_d  = '0;
    fall_d  = '0;
    if (en) begin
      if (svc == SVC_LOAD) begin
        prev_d[ptr_q]  = s_sel;
        count_d[ptr_q] = '0;
      end else if (svc == SVC_COUNT) begin
        count_d[ptr_q] = cnt_sel + 1'b1;
      end else if (svc == SVC_COMMIT) begin
        clean_d[ptr_q] = prev_sel;
        rise_d[ptr_q]  = prev_sel;
        fall_d[ptr_q]  = !prev_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= '0;
      prev_q  <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int i = 0; i < N_CH; i++) count_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      prev_q  <= prev_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  assign clean = clean_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule
